// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready words enter a small FIFO and leave
// LSB-first as start / data / optional parity / stop frames on a registered line.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          axiiv,
    input  logic [DATA_WIDTH-1:0]         axiid,
    output logic                          axiir,
    output logic                          axiod,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $error("uart_tx_fifo: DATA_WIDTH must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------- input FIFO ----------------
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic                  head_par;

    // Ready comes from the registered count, so a pop in the same cycle never frees a slot early.
    assign axiir    = (fifo_count != (PTR_W + 1)'(FIFO_DEPTH));
    assign push     = axiiv && axiir;
    assign head     = mem[rd_ptr];
    assign head_par = (^head) ^ (PARITY == 1);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage is left unreset; the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= axiid;
    end

    // ---------------- serializer FSM ----------------
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      baud_q, baud_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  line_d;
    logic                  baud_term;
    logic                  frame_end;

    assign baud_term = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            axiod   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            axiod   <= line_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        line_d    = 1'b1;
        pop       = 1'b0;
        frame_end = 1'b0;

        if (state_q != ST_IDLE) baud_d = baud_term ? '0 : baud_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = head_par;
                    state_d = ST_START;
                    line_d  = 1'b0;
                end
            end
            ST_START: begin
                line_d = 1'b0;
                if (baud_term) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                    line_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                line_d = shift_q[0];
                if (baud_term) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d = ST_STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                        line_d  = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                line_d = par_q;
                if (baud_term) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            end
            ST_STOP: begin
                line_d = 1'b1;
                if (baud_term) begin
                    if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                        frame_end = 1'b1;
                        // Chain straight into the next start bit when a word is waiting.
                        if (fifo_count != '0) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = head_par;
                            state_d = ST_START;
                            line_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = frame_end & ~rst;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four instances cover no parity, odd,
// even and two stop bits; a scoreboard of pushed words is matched to decoded frames.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int NI  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       vin   [NI];
    logic [7:0] din   [NI];
    logic       ready [NI];
    logic       line  [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic [2:0] cnt   [NI];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_none (
        .clk(clk), .rst(rst), .axiiv(vin[0]), .axiid(din[0]), .axiir(ready[0]),
        .axiod(line[0]), .busy(busy[0]), .done(done[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .rst(rst), .axiiv(vin[1]), .axiid(din[1]), .axiir(ready[1]),
        .axiod(line[1]), .busy(busy[1]), .done(done[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .rst(rst), .axiiv(vin[2]), .axiid(din[2]), .axiir(ready[2]),
        .axiod(line[2]), .busy(busy[2]), .done(done[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
        .clk(clk), .rst(rst), .axiiv(vin[3]), .axiid(din[3]), .axiir(ready[3]),
        .axiod(line[3]), .busy(busy[3]), .done(done[3]), .fifo_count(cnt[3]));

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         hp;
        int         nstop;
        logic       par;
    } vec_t;

    exp_t sb [$];
    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one word for one cycle at a negedge; returns at the following negedge.
    task automatic push(input int inst, input logic [7:0] d, input logic p);
        vin[inst] = 1'b1;
        din[inst] = d;
        check("push_ready", ready[inst], 1);
        sb.push_back('{d, p});
        @(negedge clk);
        vin[inst] = 1'b0;
    endtask

    // Waits (bounded) for a start bit from the current negedge, then checks every cycle of the frame.
    task automatic rx_frame(input int inst, input int hp, input int nstop, output int gap);
        exp_t       e;
        logic       eb [12];
        logic [3:0] obs;
        logic [7:0] got;
        logic       par_got;
        logic       busy_ok;
        int         nb, done_n, done_at;
        gap = 0;
        while (line[inst] !== 1'b0 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        if (line[inst] !== 1'b0) begin
            check("rx_start_timeout", line[inst], 0);
            return;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
            return;
        end
        e  = sb.pop_front();
        nb = 1 + 8 + hp + nstop;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[1+i] = e.data[i];
        if (hp != 0) eb[9] = e.par;
        for (int j = 0; j < nstop; j++) eb[9+hp+j] = 1'b1;
        done_n  = 0;
        done_at = -1;
        busy_ok = 1'b1;
        got     = '0;
        par_got = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                obs[s] = line[inst];
                if (busy[inst] !== 1'b1) busy_ok = 1'b0;
                if (done[inst] !== 1'b0) begin
                    done_n++;
                    done_at = b * CPB + s;
                end
                if (s == CPB / 2 && b >= 1 && b <= 8) got[b-1] = line[inst];
                if (s == CPB / 2 && hp != 0 && b == 9) par_got = line[inst];
            end
            check($sformatf("bit%0d", b), obs, {4{eb[b]}});
        end
        check("rx_data", got, e.data);
        if (hp != 0) check("rx_parity", par_got, e.par);
        check("busy_in_frame", busy_ok, 1);
        check("done_count", done_n, 1);
        check("done_pos", done_at, nb * CPB - 1);
    endtask

    task automatic check_idle(input int inst);
        @(negedge clk);
        check("idle_busy", busy[inst], 0);
        check("idle_line", line[inst], 1);
        check("idle_count", cnt[inst], 0);
        check("idle_ready", ready[inst], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap, highs, bad;

        // {instance, word, parity enabled, stop bits, expected parity bit}
        vecs[0] = '{0, 8'hAA, 0, 1, 1'b0};
        vecs[1] = '{2, 8'hCC, 1, 1, 1'b0};
        vecs[2] = '{1, 8'hCC, 1, 1, 1'b1};
        vecs[3] = '{2, 8'h07, 1, 1, 1'b1};
        vecs[4] = '{3, 8'hFF, 0, 2, 1'b0};

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            vin[i] = 1'b0;
            din[i] = 8'h00;
        end
        vin[0] = 1'b1;
        din[0] = 8'h5A;

        // Reset held three cycles with a word offered
        repeat (3) @(negedge clk);
        check("rst_axiod", line[0], 1);
        check("rst_axiir", ready[0], 1);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_count", cnt[0], 0);
        rst    = 1'b0;
        vin[0] = 1'b0;
        @(negedge clk);
        check("post_rst_count", cnt[0], 0);
        check("post_rst_line", line[0], 1);

        // Single frames across parity / stop-bit variants
        for (int v = 0; v < 5; v++) begin
            push(vecs[v].inst, vecs[v].data, vecs[v].par);
            rx_frame(vecs[v].inst, vecs[v].hp, vecs[v].nstop, gap);
            check("latency_gap", gap, 1);
            check_idle(vecs[v].inst);
        end

        // Back-to-back words on consecutive cycles
        push(0, 8'hAA, 1'b0);
        push(0, 8'hCC, 1'b0);
        check("b2b_push_pop_count", cnt[0], 1);
        rx_frame(0, 0, 1, gap);
        check("b2b_first_start", gap, 0);
        rx_frame(0, 0, 1, gap);
        check("b2b_gap", gap, 1);
        check_idle(0);

        // Overflow: fill the FIFO while the first frame is on the line
        push(0, 8'h01, 1'b0);
        fork
            begin
                int g;
                for (int k = 0; k < 5; k++) begin
                    rx_frame(0, 0, 1, g);
                    check("ovf_gap", g, 1);
                end
            end
            begin
                int         t, mc;
                logic [7:0] d;
                t = 0;
                while (busy[0] !== 1'b1 && t < 10) begin
                    @(negedge clk);
                    t++;
                end
                check("ovf_wait_busy", busy[0], 1);
                check("ovf_empty", cnt[0], 0);
                mc = 0;
                d  = 8'h02;
                for (int i = 0; i < 7; i++) begin
                    vin[0] = 1'b1;
                    din[0] = d;
                    check("ovf_ready", ready[0], (mc < 4) ? 1 : 0);
                    @(negedge clk);
                    if (mc < 4) begin
                        sb.push_back('{d, 1'b0});
                        mc++;
                        d++;
                    end
                end
                vin[0] = 1'b0;
                check("ovf_full_count", cnt[0], 4);
                check("ovf_full_ready", ready[0], 0);
            end
        join
        check_idle(0);
        highs = 0;
        repeat (20) begin
            @(negedge clk);
            if (line[0] === 1'b1) highs++;
        end
        check("ovf_no_extra_frame", highs, 20);
        check("sb_empty", sb.size(), 0);

        // Reset during data bit 3 with a second word still buffered
        push(3, 8'hA5, 1'b0);
        push(3, 8'h3C, 1'b0);
        check("abort_start", line[3], 0);
        repeat (17) @(negedge clk);
        check("abort_pre_line", line[3], 0);
        check("abort_pre_count", cnt[3], 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_line", line[3], 1);
        check("abort_busy", busy[3], 0);
        check("abort_count", cnt[3], 0);
        check("abort_done", done[3], 0);
        rst = 1'b0;
        sb.delete();
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (line[3] !== 1'b1 || busy[3] !== 1'b0 || done[3] !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
